pc_branch_ctrl: RTL and testbench

Program-counter register and branch-resolution sequencer for the multicycle MIPS datapath. It sits directly downstream of the branch-condition select stage. It computes the EQ and signed-GT flags from the ALU operands and picks one of EQ, ~EQ, GT or ~GT according to the branch opcode. It then commits the PC one cycle later if the selected condition holds. Unconditional PC writes (fetch increment, jump, jr) and taken/not-taken statistics for the control unit and debug also live here.

---
 rtl/pc_branch_ctrl.sv | 94 +++++++++
 tb/tb_pc_branch_ctrl.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/pc_branch_ctrl.sv
// pc_branch_ctrl: PC register with a two-state branch resolver and saturating taken/not-taken counters.
module pc_branch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             pc_write,
  input  logic             pc_write_cond,
  input  logic [1:0]       pc_source,
  input  logic [1:0]       branch_op,
  input  logic [31:0]      src_a,
  input  logic [31:0]      src_b,
  input  logic [31:0]      alu_result,
  input  logic [31:0]      alu_out,
  input  logic [25:0]      jump_index,
  output logic [31:0]      pc,
  output logic             busy,
  output logic             branch_taken,
  output logic             eq_flag,
  output logic             gt_flag,
  output logic [CNT_W-1:0] taken_count,
  output logic [CNT_W-1:0] not_taken_count
);
  localparam logic IDLE = 1'b0;
  localparam logic EVAL = 1'b1;
  logic             state_q, state_d;
  logic [31:0]      pc_q, pc_d, tgt_q, tgt_d, uncond_pc;
  logic [1:0]       op_q, op_d;
  logic             eq_q, eq_d, gt_q, gt_d, taken_q, taken_d, cond;
  logic [CNT_W-1:0] tc_q, tc_d, ntc_q, ntc_d;
  always_comb begin
    cond = op_q == 2'b00 ? eq_q : op_q == 2'b01 ? ~eq_q : op_q == 2'b10 ? gt_q : ~gt_q;
    uncond_pc = pc_source == 2'b00 ? alu_result :
                pc_source == 2'b01 ? alu_out :
                pc_source == 2'b10 ? {pc_q[31:28], jump_index, 2'b00} : src_a;
    state_d = IDLE;
    pc_d    = pc_q;
    tgt_d   = tgt_q;
    op_d    = op_q;
    eq_d    = eq_q;
    gt_d    = gt_q;
    taken_d = 1'b0;
    tc_d    = tc_q;
    ntc_d   = ntc_q;
    if (state_q == IDLE) begin
      if (pc_write) begin
        pc_d = uncond_pc;
      end else if (pc_write_cond) begin
        eq_d    = src_a == src_b;
        gt_d    = $signed(src_a) > $signed(src_b);
        op_d    = branch_op;
        tgt_d   = alu_out;
        state_d = EVAL;
      end
    end else if (cond) begin
      pc_d    = tgt_q;
      taken_d = 1'b1;
      tc_d    = &tc_q ? tc_q : tc_q + 1'b1;
    end else begin
      ntc_d = &ntc_q ? ntc_q : ntc_q + 1'b1;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      tgt_q   <= '0;
      op_q    <= '0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
      taken_q <= 1'b0;
      tc_q    <= '0;
      ntc_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      op_q    <= op_d;
      eq_q    <= eq_d;
      gt_q    <= gt_d;
      taken_q <= taken_d;
      tc_q    <= tc_d;
      ntc_q   <= ntc_d;
    end
  end
  assign pc              = pc_q;
  assign busy            = state_q == EVAL;
  assign branch_taken    = taken_q;
  assign eq_flag         = eq_q;
  assign gt_flag         = gt_q;
  assign taken_count     = tc_q;
  assign not_taken_count = ntc_q;
endmodule

// File: tb/tb_pc_branch_ctrl.sv
// tb_pc_branch_ctrl: directed scenarios with hand-computed expectations; CNT_W=2 so saturation is reachable.
module tb_pc_branch_ctrl;
  logic        clk, reset_n, pc_write, pc_write_cond;
  logic [1:0]  pc_source, branch_op;
  logic [31:0] src_a, src_b, alu_result, alu_out, pc;
  logic [25:0] jump_index;
  logic        busy, branch_taken, eq_flag, gt_flag;
  logic [1:0]  taken_count, not_taken_count;
  int tests = 0;
  int errs = 0;

  pc_branch_ctrl #(.RESET_PC(32'h0), .CNT_W(2)) dut (
    .clk(clk), .reset_n(reset_n), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .pc_source(pc_source), .branch_op(branch_op), .src_a(src_a), .src_b(src_b),
    .alu_result(alu_result), .alu_out(alu_out), .jump_index(jump_index), .pc(pc),
    .busy(busy), .branch_taken(branch_taken), .eq_flag(eq_flag), .gt_flag(gt_flag),
    .taken_count(taken_count), .not_taken_count(not_taken_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; pc_write = 1'b0; pc_write_cond = 1'b0; pc_source = 2'b00; branch_op = 2'b00;
    src_a = '0; src_b = '0; alu_result = '0; alu_out = '0; jump_index = '0;
    #12;
    tests++; if (pc !== 32'h0) begin errs++; $display("FAIL reset_pc got %h exp %h", pc, 32'h0); end
    tests++; if (busy !== 1'b0 || branch_taken !== 1'b0) begin errs++; $display("FAIL reset_busy_taken got %b%b exp 00", busy, branch_taken); end
    tests++; if (eq_flag !== 1'b0 || gt_flag !== 1'b0) begin errs++; $display("FAIL reset_flags got %b%b exp 00", eq_flag, gt_flag); end
    tests++; if (taken_count !== 2'd0 || not_taken_count !== 2'd0) begin errs++; $display("FAIL reset_counts got %0d/%0d exp 0/0", taken_count, not_taken_count); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_fetch_jump();
    pc_write = 1'b1; pc_source = 2'b00; alu_result = 32'h4;
    tick();
    tests++; if (pc !== 32'h4) begin errs++; $display("FAIL fetch_pc got %h exp %h", pc, 32'h4); end
    alu_result = 32'hA000_0004;
    tick();
    pc_source = 2'b10; jump_index = 26'h10;
    tick();
    tests++; if (pc !== 32'hA000_0040) begin errs++; $display("FAIL jump_pc got %h exp %h", pc, 32'hA000_0040); end
    pc_source = 2'b11; src_a = 32'h200;
    tick();
    tests++; if (pc !== 32'h200) begin errs++; $display("FAIL jr_pc got %h exp %h", pc, 32'h200); end
    pc_source = 2'b01; alu_out = 32'h300;
    tick();
    tests++; if (pc !== 32'h300) begin errs++; $display("FAIL aluout_pc got %h exp %h", pc, 32'h300); end
    pc_write = 1'b0;
    tick();
    tests++; if (pc !== 32'h300) begin errs++; $display("FAIL hold_pc got %h exp %h", pc, 32'h300); end
  endtask

  task automatic test_beq();
    src_a = 32'd7; src_b = 32'd7; branch_op = 2'b00; alu_out = 32'h100; pc_write_cond = 1'b1;
    tick();
    pc_write_cond = 1'b0;
    tests++; if (busy !== 1'b1 || eq_flag !== 1'b1 || gt_flag !== 1'b0) begin errs++; $display("FAIL beq_eval busy/eq/gt got %b%b%b exp 110", busy, eq_flag, gt_flag); end
    tests++; if (pc !== 32'h300 || branch_taken !== 1'b0) begin errs++; $display("FAIL beq_eval_pc got %h/%b exp 300/0", pc, branch_taken); end
    tick();
    tests++; if (pc !== 32'h100 || branch_taken !== 1'b1 || busy !== 1'b0) begin errs++; $display("FAIL beq_commit got pc=%h bt=%b busy=%b exp 100/1/0", pc, branch_taken, busy); end
    tests++; if (taken_count !== 2'd1 || not_taken_count !== 2'd0) begin errs++; $display("FAIL beq_counts got %0d/%0d exp 1/0", taken_count, not_taken_count); end
    tick();
    tests++; if (branch_taken !== 1'b0) begin errs++; $display("FAIL beq_pulse got %b exp 0", branch_taken); end
    src_b = 32'd8; alu_out = 32'h400; pc_write_cond = 1'b1;
    tick();
    pc_write_cond = 1'b0;
    tests++; if (busy !== 1'b1 || eq_flag !== 1'b0 || gt_flag !== 1'b0) begin errs++; $display("FAIL bne_eval busy/eq/gt got %b%b%b exp 100", busy, eq_flag, gt_flag); end
    tick();
    tests++; if (pc !== 32'h100 || branch_taken !== 1'b0 || busy !== 1'b0) begin errs++; $display("FAIL beq_not_taken got pc=%h bt=%b busy=%b exp 100/0/0", pc, branch_taken, busy); end
    tests++; if (taken_count !== 2'd1 || not_taken_count !== 2'd1) begin errs++; $display("FAIL beq_nt_counts got %0d/%0d exp 1/1", taken_count, not_taken_count); end
  endtask

  task automatic test_signed_gt();
    src_a = 32'hFFFF_FFFF; src_b = 32'd1; branch_op = 2'b10; alu_out = 32'h500; pc_write_cond = 1'b1;
    tick();
    pc_write_cond = 1'b0;
    tests++; if (gt_flag !== 1'b0 || eq_flag !== 1'b0) begin errs++; $display("FAIL sgt_flags got %b%b exp 00", gt_flag, eq_flag); end
    tick();
    tests++; if (pc !== 32'h100 || not_taken_count !== 2'd2) begin errs++; $display("FAIL sgt_not_taken got pc=%h nt=%0d exp 100/2", pc, not_taken_count); end
    branch_op = 2'b11; pc_write_cond = 1'b1;
    tick();
    pc_write_cond = 1'b0;
    tick();
    tests++; if (pc !== 32'h500 || branch_taken !== 1'b1 || taken_count !== 2'd2) begin errs++; $display("FAIL sle_taken got pc=%h bt=%b t=%0d exp 500/1/2", pc, branch_taken, taken_count); end
    src_a = 32'd5; src_b = 32'hFFFF_FFFE; branch_op = 2'b10; alu_out = 32'h540; pc_write_cond = 1'b1;
    tick();
    pc_write_cond = 1'b0;
    tests++; if (gt_flag !== 1'b1) begin errs++; $display("FAIL sgt_pos_flag got %b exp 1", gt_flag); end
    tick();
    tests++; if (pc !== 32'h540 || taken_count !== 2'd3) begin errs++; $display("FAIL sgt_taken got pc=%h t=%0d exp 540/3", pc, taken_count); end
  endtask

  task automatic test_collision();
    pc_write = 1'b1; pc_write_cond = 1'b1; pc_source = 2'b00; alu_result = 32'h600;
    src_a = 32'd5; src_b = 32'd5; branch_op = 2'b00; alu_out = 32'h650;
    tick();
    pc_write = 1'b0; pc_write_cond = 1'b0;
    tests++; if (pc !== 32'h600 || busy !== 1'b0 || eq_flag !== 1'b0 || gt_flag !== 1'b1) begin errs++; $display("FAIL collide got pc=%h busy=%b eq=%b gt=%b exp 600/0/0/1", pc, busy, eq_flag, gt_flag); end
    tick();
    tests++; if (pc !== 32'h600 || taken_count !== 2'd3 || not_taken_count !== 2'd2) begin errs++; $display("FAIL collide_after got pc=%h t=%0d nt=%0d exp 600/3/2", pc, taken_count, not_taken_count); end
    alu_out = 32'h700; pc_write_cond = 1'b1;
    tick();
    pc_write_cond = 1'b0; pc_write = 1'b1; alu_result = 32'h800; alu_out = 32'h880;
    tick();
    pc_write = 1'b0;
    tests++; if (pc !== 32'h700 || branch_taken !== 1'b1) begin errs++; $display("FAIL eval_ignores_write got pc=%h bt=%b exp 700/1", pc, branch_taken); end
    tick();
    tests++; if (pc !== 32'h700 || busy !== 1'b0) begin errs++; $display("FAIL eval_no_queue got pc=%h busy=%b exp 700/0", pc, busy); end
  endtask

  task automatic test_back_to_back();
    src_a = 32'd9; src_b = 32'd9; branch_op = 2'b00; alu_out = 32'hA00; pc_write_cond = 1'b1;
    tick();
    alu_out = 32'hB00;
    tick();
    tests++; if (pc !== 32'hA00 || branch_taken !== 1'b1 || busy !== 1'b0) begin errs++; $display("FAIL b2b_first got pc=%h bt=%b busy=%b exp a00/1/0", pc, branch_taken, busy); end
    tick();
    pc_write_cond = 1'b0;
    tests++; if (busy !== 1'b1) begin errs++; $display("FAIL b2b_accept busy got %b exp 1", busy); end
    tick();
    tests++; if (pc !== 32'hB00 || taken_count !== 2'd3) begin errs++; $display("FAIL sat_taken got pc=%h t=%0d exp b00/3", pc, taken_count); end
    tests++; if (not_taken_count !== 2'd2) begin errs++; $display("FAIL sat_nt got %0d exp 2", not_taken_count); end
    tick();
  endtask

  task automatic test_reset_mid_eval();
    src_a = 32'd1; src_b = 32'd1; branch_op = 2'b00; alu_out = 32'hC00; pc_write_cond = 1'b1;
    tick();
    pc_write_cond = 1'b0;
    tests++; if (busy !== 1'b1) begin errs++; $display("FAIL mid_busy got %b exp 1", busy); end
    #2 reset_n = 1'b0;
    #1;
    tests++; if (pc !== 32'h0 || busy !== 1'b0 || taken_count !== 2'd0 || eq_flag !== 1'b0) begin errs++; $display("FAIL async_reset got pc=%h busy=%b t=%0d eq=%b exp 0/0/0/0", pc, busy, taken_count, eq_flag); end
    #10 reset_n = 1'b1;
    tick();
    tick();
    tests++; if (pc !== 32'h0 || branch_taken !== 1'b0 || taken_count !== 2'd0) begin errs++; $display("FAIL reset_discard got pc=%h bt=%b t=%0d exp 0/0/0", pc, branch_taken, taken_count); end
  endtask

  initial begin
    test_reset();
    test_fetch_jump();
    test_beq();
    test_signed_gt();
    test_collision();
    test_back_to_back();
    test_reset_mid_eval();
    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end
endmodule
